// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the slave modport; the byte source and memory side use master.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses starting at a programmable base.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
// (wrapping sum of all data words) and a chk_err result output.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LEN_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] num_words,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_written
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic             chk_err
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [1:0]       byte_q;
    logic [23:0]      part_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    // Set while the bytes being collected form the checksum word, not data.
    logic             chk_phase_q;
    logic             start_ok;
    logic             accept;
    logic             last_byte;
    logic             last_word;
    logic [31:0]      word_full;

    assign start_ok  = (state_q == IDLE) && start;
    assign accept    = (state_q == COLLECT) && bus.in_valid;
    assign last_byte = (byte_q == 2'd3);
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign last_word = (cnt_inc == len_q);
    assign word_full = {part_q, bus.in_data};

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign words_written = cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_words == '0 && !CHK_EN) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (accept && last_byte) begin
                    state_d = chk_phase_q ? FINISH : WRITE;
                end
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
                state_d    = (last_word && !CHK_EN) ? FINISH : COLLECT;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load parameters, byte packing, write address/data and word counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            part_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            chk_phase_q <= 1'b0;
        end else begin
            if (start_ok) begin
                idx_q       <= base_addr[IDX_W+1:2];
                len_q       <= num_words;
                cnt_q       <= '0;
                byte_q      <= '0;
                chk_phase_q <= CHK_EN && (num_words == '0);
            end
            if (accept) begin
                byte_q <= byte_q + 2'd1;
                part_q <= {part_q[15:0], bus.in_data};
                // Capture the write beat here so it is presented during WRITE.
                if (last_byte && !chk_phase_q) begin
                    addr_q  <= {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                    wdata_q <= word_full;
                end
            end
            if (state_q == WRITE) begin
                cnt_q <= cnt_inc;
                idx_q <= idx_q + 1'b1;
                if (last_word) begin
                    chk_phase_q <= CHK_EN;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        chk_err_q;

    // Running sum of written words and comparison against the trailing checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                sum_q     <= '0;
                chk_err_q <= 1'b0;
            end
            if (state_q == WRITE) begin
                sum_q <= sum_q + wdata_q;
            end
            if (accept && last_byte && chk_phase_q) begin
                chk_err_q <= (word_full != sum_q);
            end
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed spec cases plus randomized loads
// checked against an address/data reference computed from the loading rules.
module tb_imem_loader;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LW    = 11;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    // Cycles from the last data write (or accepted start when empty) to done, full-rate input.
    localparam int DONE_LAG = CHK ? 5 : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [LW-1:0] num_words = '0;
    logic          busy, done;
    logic [LW-1:0] words_written;
    logic          chk_err_s;

    imem_loader_if bus();

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic chk_err;
    assign chk_err_s = chk_err;
`else
    assign chk_err_s = 1'b0;
`endif

    imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .chk_err      (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every write beat and done pulse.
    logic [31:0]   we_addr[$];
    logic [31:0]   we_data[$];
    int            we_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [LW-1:0] done_ww = '0;
    logic          done_chk = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_addr.push_back(bus.mem_addr);
            we_data.push_back(bus.mem_wdata);
            we_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_ww  = words_written;
            done_chk = chk_err_s;
        end
    end

    // Load image and bookkeeping shared by the tests.
    logic [31:0] dw[0:15];
    logic [31:0] chk_word;
    int          we0, d0, t_start;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_at(input int n, input int p);
        logic [31:0] w;
        w = (p / 4 < n) ? dw[p / 4] : chk_word;
        return 8'(w >> (24 - 8 * (p % 4)));
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
        return (((base >> 2) + i) % DEPTH) * 4;
    endfunction

    // vmode: 0 = in_valid always high, 1 = toggles every cycle, 2 = random.
    task automatic drive_load(input logic [31:0] base, input int n, input int vmode,
                              input bit mid_start);
        int total, ptr, budget;
        bit v;
        we0 = we_addr.size();
        d0  = done_cnt;
        tick();
        start = 1'b1; base_addr = base; num_words = LW'(n); t_start = cyc;
        tick();
        start = 1'b0; base_addr = $urandom; num_words = LW'($urandom);
        total = 4 * n + (CHK ? 4 : 0);
        ptr = 0;
        budget = 0;
        while (ptr < total && budget < 2000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 2 == 0)
                                                  : ($urandom_range(0, 99) < 60);
            bus.in_valid = v;
            bus.in_data  = v ? byte_at(n, ptr) : 8'($urandom);
            start        = mid_start && (ptr == 2);
            if (v && bus.in_ready) ptr++;
            budget++;
            tick();
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick(); tick(); tick();
        checks++;
        if (ptr < total || done_cnt == d0) begin
            errors++;
            $display("FAIL load_timeout: bytes %0d of %0d, done pulses %0d, required all bytes and done",
                     ptr, total, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tick(); tick();
        checks++;
        if ({bus.in_ready, bus.mem_we, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {bus.in_ready, bus.mem_we, busy, done});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: addr %h data %h required 0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (words_written !== '0 || chk_err_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: ww %0d chk %b required 0", words_written, chk_err_s);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        dw[0] = 32'h12345678;
        dw[1] = 32'h9ABCDEF0;
        chk_word = dw[0] + dw[1];
        drive_load(32'h100, 2, 0, 1'b0);
        checks++;
        if (we_addr.size() - we0 != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d writes required 2", we_addr.size() - we0);
        end
        checks++;
        if (we_addr[we0] !== 32'h100 || we_data[we0] !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_w0: got %h:%h required 00000100:12345678", we_addr[we0], we_data[we0]);
        end
        checks++;
        if (we_addr[we0+1] !== 32'h104 || we_data[we0+1] !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL basic_w1: got %h:%h required 00000104:9abcdef0",
                     we_addr[we0+1], we_data[we0+1]);
        end
        checks++;
        if (we_cyc[we0] != t_start + 5 || we_cyc[we0+1] != t_start + 10) begin
            errors++;
            $display("FAIL basic_latency: writes at +%0d,+%0d required +5,+10",
                     we_cyc[we0] - t_start, we_cyc[we0+1] - t_start);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != we_cyc[we0+1] + DONE_LAG || done_ww !== 2) begin
            errors++;
            $display("FAIL basic_done: pulses %0d lag %0d ww %0d required 1 %0d 2",
                     done_cnt - d0, done_cyc - we_cyc[we0+1], done_ww, DONE_LAG);
        end
        checks++;
        if (busy !== 1'b0 || words_written !== 2) begin
            errors++;
            $display("FAIL basic_idle: busy %b ww %0d required 0 2", busy, words_written);
        end
    endtask

    task automatic test_stall();
        dw[0] = $urandom;
        chk_word = dw[0];
        drive_load(32'h40, 1, 1, 1'b0);
        checks++;
        if (we_addr.size() - we0 != 1 || we_addr[we0] !== 32'h40 || we_data[we0] !== dw[0]) begin
            errors++;
            $display("FAIL stall_write: n %0d got %h:%h required 00000040:%h",
                     we_addr.size() - we0, we_addr[we0], we_data[we0], dw[0]);
        end
        checks++;
        if (done_ww !== 1) begin
            errors++;
            $display("FAIL stall_ww: got %0d required 1", done_ww);
        end
    endtask

    task automatic test_wrap();
        dw[0] = $urandom;
        dw[1] = $urandom;
        chk_word = dw[0] + dw[1];
        drive_load(32'hFFE, 2, 0, 1'b0);
        checks++;
        if (we_addr[we0] !== 32'hFFC || we_addr[we0+1] !== 32'h000) begin
            errors++;
            $display("FAIL wrap_addr: got %h,%h required 00000ffc,00000000",
                     we_addr[we0], we_addr[we0+1]);
        end
        checks++;
        if (we_data[we0] !== dw[0] || we_data[we0+1] !== dw[1]) begin
            errors++;
            $display("FAIL wrap_data: got %h,%h required %h,%h",
                     we_data[we0], we_data[we0+1], dw[0], dw[1]);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        chk_word = 32'h0;
        drive_load(32'h80, 0, 0, 1'b0);
        checks++;
        if (we_addr.size() != we0 || done_cnt - d0 != 1 || done_cyc != t_start + DONE_LAG) begin
            errors++;
            $display("FAIL zero_len: writes %0d pulses %0d lag %0d required 0 1 %0d",
                     we_addr.size() - we0, done_cnt - d0, done_cyc - t_start, DONE_LAG);
        end
        checks++;
        if (done_ww !== 0 || done_chk !== 1'b0) begin
            errors++;
            $display("FAIL zero_ww: ww %0d chk %b required 0 0", done_ww, done_chk);
        end
        dw[0] = $urandom;
        chk_word = dw[0];
        drive_load(32'h200, 1, 0, 1'b1);
        checks++;
        if (we_addr.size() - we0 != 1 || we_addr[we0] !== 32'h200 || we_data[we0] !== dw[0]
            || done_ww !== 1) begin
            errors++;
            $display("FAIL ignored_start: n %0d got %h:%h ww %0d required 1 00000200:%h 1",
                     we_addr.size() - we0, we_addr[we0], we_data[we0], done_ww, dw[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        dw[0] = 32'hCAFEF00D;
        chk_word = dw[0];
        we0 = we_addr.size();
        tick();
        start = 1'b1; base_addr = 32'h300; num_words = LW'(1);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hCA;
        tick();
        bus.in_data = 8'hFE;
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_we, busy, done} !== 4'b0 || words_written !== '0
            || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ctrl %b ww %0d addr %h data %h required all 0",
                     {bus.in_ready, bus.mem_we, busy, done}, words_written,
                     bus.mem_addr, bus.mem_wdata);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (we_addr.size() != we0) begin
            errors++;
            $display("FAIL midreset_nowrite: got %0d writes required 0", we_addr.size() - we0);
        end
        drive_load(32'h300, 1, 0, 1'b0);
        checks++;
        if (we_addr.size() - we0 != 1 || we_addr[we0] !== 32'h300 || we_data[we0] !== dw[0]) begin
            errors++;
            $display("FAIL midreset_reload: n %0d got %h:%h required 00000300:%h",
                     we_addr.size() - we0, we_addr[we0], we_data[we0], dw[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic [31:0] base;
            n = $urandom_range(1, 6);
            base = $urandom;
            chk_word = '0;
            for (int i = 0; i < n; i++) begin
                dw[i] = $urandom;
                chk_word = chk_word + dw[i];
            end
            drive_load(base, n, $urandom_range(0, 2), 1'b0);
            checks++;
            if (we_addr.size() - we0 != n) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d writes required %0d",
                         it, we_addr.size() - we0, n);
            end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (we_addr[we0+i] !== exp_addr(base, i) || we_data[we0+i] !== dw[i]) begin
                    errors++;
                    $display("FAIL rand_write[%0d.%0d]: got %h:%h required %h:%h", it, i,
                             we_addr[we0+i], we_data[we0+i], exp_addr(base, i), dw[i]);
                end
            end
            checks++;
            if (done_cnt - d0 != 1 || done_ww !== LW'(n) || done_chk !== 1'b0) begin
                errors++;
                $display("FAIL rand_done[%0d]: pulses %0d ww %0d chk %b required 1 %0d 0",
                         it, done_cnt - d0, done_ww, done_chk, n);
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        dw[0] = 32'h1;
        dw[1] = 32'h2;
        chk_word = 32'h3;
        drive_load(32'h0, 2, 0, 1'b0);
        checks++;
        if (done_chk !== 1'b0 || we_addr.size() - we0 != 2) begin
            errors++;
            $display("FAIL chk_good: chk %b writes %0d required 0 2", done_chk, we_addr.size() - we0);
        end
        chk_word = 32'h4;
        drive_load(32'h0, 2, 0, 1'b0);
        checks++;
        if (done_chk !== 1'b1 || chk_err !== 1'b1 || we_addr.size() - we0 != 2) begin
            errors++;
            $display("FAIL chk_bad: chk %b held %b writes %0d required 1 1 2",
                     done_chk, chk_err, we_addr.size() - we0);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_and_ignored_start();
        test_reset_mid_load();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
